// File: rtl/axi_burst_splitter_if.sv
// Request/descriptor bundle for the burst splitter.
// The "slave" modport is the splitter itself: it accepts byte requests and
// produces burst descriptors. The "master" modport is the surrounding logic
// that issues requests and consumes descriptors.
interface axi_burst_splitter_if #(
  parameter int DATA_BYTES = 8,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 13
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic [LEN_W-1:0]      req_bytes;
  logic                  bst_valid;
  logic                  bst_ready;
  logic [ADDR_W-1:0]     bst_addr;
  logic [7:0]            bst_len;
  logic [DATA_BYTES-1:0] bst_first_strb;
  logic [DATA_BYTES-1:0] bst_last_strb;
  logic                  bst_last;
  logic                  zero_len;
  logic                  busy;

  modport slave (
    input  req_valid, req_addr, req_bytes, bst_ready,
    output req_ready, bst_valid, bst_addr, bst_len, bst_first_strb,
           bst_last_strb, bst_last, zero_len, busy
  );

  modport master (
    output req_valid, req_addr, req_bytes, bst_ready,
    input  req_ready, bst_valid, bst_addr, bst_len, bst_first_strb,
           bst_last_strb, bst_last, zero_len, busy
  );
endinterface

// File: rtl/axi_burst_splitter.sv
// Splits a byte-granular (address, count) request into bus-aligned bursts
// that never cross a BOUNDARY page and never exceed MAX_BEATS beats.
// One request in flight; one CALC cycle precedes every descriptor.
module axi_burst_splitter #(
  parameter int DATA_BYTES = 8,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 13,
  parameter int MAX_BEATS  = 256,
  parameter int BOUNDARY   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_burst_splitter_if.slave  bus
);
  localparam int OB   = $clog2(DATA_BYTES);
  localparam int BW   = $clog2(BOUNDARY);
  localparam int CW   = LEN_W + 1;
  localparam int MAXB = MAX_BEATS * DATA_BYTES;
  localparam int MW   = $clog2(MAXB) + 1;
  localparam int PW   = BW + 1;
  localparam int W1   = (CW > PW) ? CW : PW;
  localparam int WW   = (W1 > MW) ? W1 : MW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t                state_r;
  logic [ADDR_W-1:0]     cur_addr_r;
  logic [LEN_W-1:0]      remaining_r;
  logic [LEN_W-1:0]      chunk_r;
  logic                  req_ready_r;
  logic                  bst_valid_r;
  logic [ADDR_W-1:0]     bst_addr_r;
  logic [7:0]            bst_len_r;
  logic [DATA_BYTES-1:0] bst_first_strb_r;
  logic [DATA_BYTES-1:0] bst_last_strb_r;
  logic                  bst_last_r;
  logic                  zero_len_r;
  logic                  busy_r;

  logic [OB-1:0]         off_s;
  logic [BW-1:0]         pg_off_s;
  logic [WW-1:0]         page_left_s;
  logic [WW-1:0]         max_left_s;
  logic [WW-1:0]         rem_w_s;
  logic [WW-1:0]         chunk_a_s;
  logic [WW-1:0]         chunk_w_s;
  logic [LEN_W-1:0]      chunk_s;
  logic [CW-1:0]         span_s;
  logic [CW-1:0]         span_m1_s;
  logic [OB-1:0]         last_idx_s;
  logic [7:0]            len_s;
  logic [ADDR_W-1:0]     align_addr_s;
  logic [DATA_BYTES-1:0] first_strb_s;
  logic [DATA_BYTES-1:0] last_strb_s;

  // Burst geometry for the current position: chunk size, beat count, strobes.
  always_comb begin
    off_s        = cur_addr_r[OB-1:0];
    pg_off_s     = cur_addr_r[BW-1:0];
    page_left_s  = WW'(BOUNDARY) - WW'(pg_off_s);
    max_left_s   = WW'(MAXB) - WW'(off_s);
    rem_w_s      = WW'(remaining_r);
    chunk_a_s    = (page_left_s < rem_w_s) ? page_left_s : rem_w_s;
    chunk_w_s    = (max_left_s < chunk_a_s) ? max_left_s : chunk_a_s;
    // chunk never exceeds remaining, so it always fits the request width
    chunk_s      = LEN_W'(chunk_w_s);
    span_s       = CW'(off_s) + CW'(chunk_s);
    // chunk >= 1 in CALC, so span-1 never underflows there
    span_m1_s    = span_s - CW'(1'b1);
    len_s        = 8'(span_m1_s >> OB);
    last_idx_s   = span_m1_s[OB-1:0];
    align_addr_s = {cur_addr_r[ADDR_W-1:OB], {OB{1'b0}}};
    first_strb_s = {DATA_BYTES{1'b1}} << off_s;
    // ~last_idx equals (DATA_BYTES-1 - last_idx) within OB bits
    last_strb_s  = {DATA_BYTES{1'b1}} >> (~last_idx_s);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= IDLE;
      cur_addr_r       <= {ADDR_W{1'b0}};
      remaining_r      <= {LEN_W{1'b0}};
      chunk_r          <= {LEN_W{1'b0}};
      req_ready_r      <= 1'b1;
      bst_valid_r      <= 1'b0;
      bst_addr_r       <= {ADDR_W{1'b0}};
      bst_len_r        <= 8'd0;
      bst_first_strb_r <= {DATA_BYTES{1'b0}};
      bst_last_strb_r  <= {DATA_BYTES{1'b0}};
      bst_last_r       <= 1'b0;
      zero_len_r       <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      zero_len_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_bytes == {LEN_W{1'b0}}) begin
              zero_len_r <= 1'b1;
            end else begin
              cur_addr_r  <= bus.req_addr;
              remaining_r <= bus.req_bytes;
              req_ready_r <= 1'b0;
              busy_r      <= 1'b1;
              state_r     <= CALC;
            end
          end
        end
        CALC: begin
          chunk_r          <= chunk_s;
          bst_addr_r       <= align_addr_s;
          bst_len_r        <= len_s;
          bst_last_r       <= (chunk_s == remaining_r);
          bst_valid_r      <= 1'b1;
          state_r          <= ISSUE;
          if (len_s == 8'd0) begin
            bst_first_strb_r <= first_strb_s & last_strb_s;
            bst_last_strb_r  <= first_strb_s & last_strb_s;
          end else begin
            bst_first_strb_r <= first_strb_s;
            bst_last_strb_r  <= last_strb_s;
          end
        end
        ISSUE: begin
          if (bus.bst_ready) begin
            bst_valid_r <= 1'b0;
            if (bst_last_r) begin
              req_ready_r <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= IDLE;
            end else begin
              cur_addr_r  <= cur_addr_r + ADDR_W'(chunk_r);
              remaining_r <= remaining_r - chunk_r;
              state_r     <= CALC;
            end
          end
        end
        default: begin
          req_ready_r <= 1'b1;
          bst_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = req_ready_r;
  assign bus.bst_valid      = bst_valid_r;
  assign bus.bst_addr       = bst_addr_r;
  assign bus.bst_len        = bst_len_r;
  assign bus.bst_first_strb = bst_first_strb_r;
  assign bus.bst_last_strb  = bst_last_strb_r;
  assign bus.bst_last       = bst_last_r;
  assign bus.zero_len       = zero_len_r;
  assign bus.busy           = busy_r;
endmodule

// File: tb/tb_axi_burst_splitter.sv
// Table-driven bench for axi_burst_splitter with a descriptor scoreboard.
module tb_axi_burst_splitter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axi_burst_splitter_if #(.DATA_BYTES(8), .ADDR_W(32), .LEN_W(13)) bus ();

  axi_burst_splitter #(
    .DATA_BYTES(8), .ADDR_W(32), .LEN_W(13), .MAX_BEATS(256), .BOUNDARY(4096)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  fs;
    logic [7:0]  ls;
    logic        last;
  } burst_t;

  typedef struct {
    logic [31:0] req_addr;
    logic [12:0] req_bytes;
    int          nb;
    burst_t      b [3];
  } vec_t;

  localparam int NV = 7;
  vec_t   vecs [NV];
  burst_t exp_q [$];
  int     n_cmp = 0;
  int     n_bad = 0;
  burst_t mon_e, mon_g;

  function automatic burst_t mk(input logic [31:0] a, input logic [7:0] l,
                                input logic [7:0] f, input logic [7:0] s,
                                input logic la);
    burst_t r;
    r.addr = a; r.len = l; r.fs = f; r.ls = s; r.last = la;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every accepted descriptor against the queue head.
  always @(negedge clk) begin
    if (!rst && bus.bst_valid && bus.bst_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_burst actual addr=%h len=%0d expected none",
                 bus.bst_addr, bus.bst_len);
      end else begin
        mon_e = exp_q.pop_front();
        mon_g = mk(bus.bst_addr, bus.bst_len, bus.bst_first_strb, bus.bst_last_strb, bus.bst_last);
        if (mon_g !== mon_e) begin
          n_bad++;
          $display("FAIL burst actual addr=%h len=%0d fs=%h ls=%h last=%b expected addr=%h len=%0d fs=%h ls=%h last=%b",
                   mon_g.addr, mon_g.len, mon_g.fs, mon_g.ls, mon_g.last,
                   mon_e.addr, mon_e.len, mon_e.fs, mon_e.ls, mon_e.last);
        end
      end
    end
  end

  function automatic logic [63:0] out_vec();
    return 64'({bus.bst_valid, bus.bst_addr, bus.bst_len, bus.bst_first_strb,
                bus.bst_last_strb, bus.bst_last, bus.zero_len, bus.busy, bus.req_ready});
  endfunction

  localparam logic [63:0] RESET_VEC = 64'h1;

  task automatic send_req(input logic [31:0] a, input logic [12:0] b, input bit chk_lat);
    int cnt;
    cnt = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_bytes = b;
    @(negedge clk);
    while (!bus.req_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("req_accept_timeout", 64'(cnt < 50), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      chk("calc_cycle_valid_ready", 64'({bus.bst_valid, bus.req_ready}), 64'd0);
      @(negedge clk);
      chk("first_valid_at_n2", 64'(bus.bst_valid), 64'd1);
    end
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || bus.busy) && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    chk("drain_timeout", 64'(cnt < 3000), 64'd1);
  endtask

  task automatic wait_valid();
    int cnt;
    cnt = 0;
    while (!bus.bst_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("valid_timeout", 64'(cnt < 50), 64'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_bytes = 13'd0;
    bus.bst_ready = 1'b1;

    vecs[0].req_addr = 32'h1005; vecs[0].req_bytes = 13'd533; vecs[0].nb = 1;
    vecs[0].b[0] = mk(32'h1000, 8'd67, 8'hE0, 8'h03, 1'b1);
    vecs[1].req_addr = 32'h0FF0; vecs[1].req_bytes = 13'd545; vecs[1].nb = 2;
    vecs[1].b[0] = mk(32'h0FF0, 8'd1, 8'hFF, 8'hFF, 1'b0);
    vecs[1].b[1] = mk(32'h1000, 8'd66, 8'hFF, 8'h01, 1'b1);
    vecs[2].req_addr = 32'h0; vecs[2].req_bytes = 13'd5000; vecs[2].nb = 3;
    vecs[2].b[0] = mk(32'h0000, 8'd255, 8'hFF, 8'hFF, 1'b0);
    vecs[2].b[1] = mk(32'h0800, 8'd255, 8'hFF, 8'hFF, 1'b0);
    vecs[2].b[2] = mk(32'h1000, 8'd112, 8'hFF, 8'hFF, 1'b1);
    vecs[3].req_addr = 32'h3; vecs[3].req_bytes = 13'd2; vecs[3].nb = 1;
    vecs[3].b[0] = mk(32'h0000, 8'd0, 8'h18, 8'h18, 1'b1);
    vecs[4].req_addr = 32'h7; vecs[4].req_bytes = 13'd1; vecs[4].nb = 1;
    vecs[4].b[0] = mk(32'h0000, 8'd0, 8'h80, 8'h80, 1'b1);
    vecs[5].req_addr = 32'hFFF9; vecs[5].req_bytes = 13'd10; vecs[5].nb = 2;
    vecs[5].b[0] = mk(32'hFFF8, 8'd0, 8'hFE, 8'hFE, 1'b0);
    vecs[5].b[1] = mk(32'h10000, 8'd0, 8'h07, 8'h07, 1'b1);
    vecs[6].req_addr = 32'hFFFF_FFFC; vecs[6].req_bytes = 13'd8; vecs[6].nb = 2;
    vecs[6].b[0] = mk(32'hFFFF_FFF8, 8'd0, 8'hF0, 8'hF0, 1'b0);
    vecs[6].b[1] = mk(32'h0000_0000, 8'd0, 8'h0F, 8'h0F, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", out_vec(), RESET_VEC);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      for (int j = 0; j < vecs[i].nb; j++) exp_q.push_back(vecs[i].b[j]);
      send_req(vecs[i].req_addr, vecs[i].req_bytes, 1'b1);
      wait_idle();
    end

    // zero-byte request: single zero_len pulse, no descriptor
    send_req(32'h100, 13'd0, 1'b0);
    @(negedge clk);
    chk("zero_len_pulse", 64'({bus.zero_len, bus.req_ready, bus.bst_valid, bus.busy}), 64'b1100);
    @(negedge clk);
    chk("zero_len_clear", 64'({bus.zero_len, bus.req_ready, bus.bst_valid, bus.busy}), 64'b0100);

    // backpressure: first descriptor of the page-crossing case held 10 cycles
    for (int j = 0; j < vecs[1].nb; j++) exp_q.push_back(vecs[1].b[j]);
    bus.bst_ready = 1'b0;
    send_req(vecs[1].req_addr, vecs[1].req_bytes, 1'b0);
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_hold",
          64'({bus.bst_valid, bus.req_ready, bus.bst_addr, bus.bst_len,
               bus.bst_first_strb, bus.bst_last_strb, bus.bst_last}),
          64'({1'b1, 1'b0, exp_q[0].addr, exp_q[0].len, exp_q[0].fs,
               exp_q[0].ls, exp_q[0].last}));
    end
    @(posedge clk); #1;
    bus.bst_ready = 1'b1;
    wait_idle();

    // reset while a descriptor is pending
    for (int j = 0; j < vecs[2].nb; j++) exp_q.push_back(vecs[2].b[j]);
    bus.bst_ready = 1'b0;
    send_req(vecs[2].req_addr, vecs[2].req_bytes, 1'b0);
    wait_valid();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_reset_outputs", out_vec(), RESET_VEC);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.bst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_reset_quiet", 64'({bus.bst_valid, bus.busy, bus.req_ready}), 64'b001);
    end
    exp_q.push_back(mk(32'h20, 8'd0, 8'hFF, 8'hFF, 1'b1));
    send_req(32'h20, 13'd8, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_burst_splitter.md
Name: axi_burst_splitter

Overview:
- Converts a byte-granular transfer request (start address, byte count) into a sequence of AXI-style burst descriptors.
- Each descriptor carries a bus-aligned address, beat length, and first/last-beat strobes.
- Bursts never cross a BOUNDARY-byte page and never exceed MAX_BEATS beats.
- Parametrised, sequential successor to the combinational single-shot strobe/beat calculator; sits between the serdes assembler front end and the AXI master write/read address channel.

Parameters:
- DATA_BYTES, 8, bus width in bytes; power of two, 2..64.
- ADDR_W, 32, address width.
- LEN_W, 13, request byte-count width.
- MAX_BEATS, 256, max beats per burst; power of two, <= 256.
- BOUNDARY, 4096, page size no burst may cross; power of two, >= MAX_BEATS*DATA_BYTES is not required.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_addr  in  ADDR_W  start byte address (any alignment).
- req_bytes  in  LEN_W  byte count; 0 is legal.
- bst_valid  out  1  descriptor valid.
- bst_ready  in  1  downstream accept.
- bst_addr  out  ADDR_W  burst address aligned down to DATA_BYTES.
- bst_len  out  8  beats-1 (AXI LEN encoding).
- bst_first_strb  out  DATA_BYTES  strobe of first beat.
- bst_last_strb  out  DATA_BYTES  strobe of last beat.
- bst_last  out  1  final burst of the current request.
- zero_len  out  1  one-cycle pulse: zero-byte request accepted and dropped.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; req_ready=1.
  - bst_valid=0, bst_addr=0, bst_len=0, both strobes=0.
  - bst_last=0, zero_len=0, busy=0.
  - Internal cur_addr and remaining cleared.
- An assertion of rst mid-request abandons the request and emits no further descriptors.
- States: IDLE, CALC, ISSUE.
- IDLE:
  - req_ready=1.
  - On req_valid with req_bytes==0: pulse zero_len next cycle and stay in IDLE.
  - On req_valid with req_bytes!=0: latch cur_addr=req_addr and remaining=req_bytes, then go to CALC.
- CALC (one cycle, req_ready=0):
  - off = cur_addr mod DATA_BYTES.
  - page_left = BOUNDARY - (cur_addr mod BOUNDARY).
  - max_left = MAX_BEATS*DATA_BYTES - off.
  - chunk = min(remaining, page_left, max_left).
  - span = off + chunk.
  - beats = ceil(span / DATA_BYTES).
  - Register the outputs:
    - bst_addr = cur_addr with low log2(DATA_BYTES) bits zeroed.
    - bst_len = beats-1.
    - bst_first_strb = all-ones << off.
    - bst_last_strb = low ((span-1) mod DATA_BYTES)+1 bits set.
    - bst_last = (chunk == remaining).
  - If beats==1, both strobes equal (first & last).
  - Go to ISSUE.
- ISSUE:
  - bst_valid=1; outputs held stable until bst_ready.
  - On handshake:
    - If bst_last: go to IDLE with bst_valid=0.
    - Else: cur_addr += chunk, remaining -= chunk, go to CALC.
- Latency:
  - Request handshake at cycle N gives the first bst_valid at N+2.
  - Subsequent bursts follow one cycle after each descriptor handshake, so there is exactly one bubble between bursts.
- Only one request is in flight; req_ready=0 from CALC until return to IDLE.
- Arithmetic:
  - Internal span/chunk width is LEN_W+1 bits.
  - cur_addr wraps modulo 2^ADDR_W with no error indication.
- bst_ready is ignored when bst_valid=0.

Test Plan:
- DATA_BYTES=8, addr=0x1005, bytes=533:
  - Expect one burst: addr 0x1000, len 67, first_strb 0xE0, last_strb 0x03, last=1.
  - bst_valid is asserted 2 cycles after the request handshake.
- addr=0x0FF0, bytes=545 (4K crossing):
  - Burst 1: addr 0x0FF0, len 1, strobes 0xFF/0xFF, last=0.
  - Burst 2: addr 0x1000, len 66, first 0xFF, last_strb 0x01, last=1.
- addr=0x0, bytes=5000, MAX_BEATS=256:
  - Three bursts: (0x0, len 255, last=0), (0x800, len 255, last=0), (0x1000, len 112, last_strb 0xFF, last=1).
- addr=0x3, bytes=2:
  - One burst: len 0, first_strb=last_strb=0x18, last=1.
  - A zero-byte request: zero_len pulses once, no bst_valid, req_ready stays 1.
- Hold bst_ready=0 for 10 cycles during the burst 2 case: descriptor outputs stable, req_ready=0 throughout.
- Assert rst while in ISSUE: all outputs return to their reset values immediately; a following request at addr 0x20, bytes 8 yields len 0, strb 0xFF/0xFF.
